// File: rtl/bin2bcd_seg_seq_pkg.sv
// Shared constants for the sequential BCD converter and its seven-segment decoders.
// Latency: n/a (constants, types and constant functions only).
// Backpressure: n/a.
// Contents: active-low segment codes for 0-9, SEG_BLANK, FSM state encoding,
//           pow10() for the overflow limit, acc_digits() for accumulator headroom.
package bin2bcd_seg_seq_pkg;

    // Active-low segments, bit order {dp,g,f,e,d,c,b,a}; dp always off.
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    // Every decimal digit covers at least 3 binary bits (8 < 10), so
    // ceil(BIN_W/3) digits always hold the full conversion.
    function automatic int acc_digits(input int bin_w, input int digits);
        int need;
        need = (bin_w + 2) / 3;
        return (need > digits) ? need : digits;
    endfunction

endpackage

// File: rtl/bin2bcd_seg_seq_if.sv
// Request/result bundle between a value source and the BCD display converter.
// Latency: n/a (wiring only).
// Backpressure: none; start is simply ignored while busy is high.
// Signals: start/bin_in (request), busy/done/ovf/bcd_out/hex_out (status and results).
interface bin2bcd_seg_seq_if #(
    parameter int BIN_W  = 10,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [BIN_W-1:0]      bin_in;
    logic                  busy;
    logic                  done;
    logic                  ovf;
    logic [4*DIGITS-1:0]   bcd_out;
    logic [8*DIGITS-1:0]   hex_out;

    modport master (
        output start, bin_in,
        input  busy, done, ovf, bcd_out, hex_out
    );

    modport slave (
        input  start, bin_in,
        output busy, done, ovf, bcd_out, hex_out
    );
endinterface

// File: rtl/bin2bcd_seg_seq_seg7_decode.sv
// One BCD digit to active-low seven-segment pattern, with forced blank.
// Latency: combinational.
// Backpressure: none.
// Ports: digit (4-bit BCD), blank (show nothing), seg ({dp,g,f,e,d,c,b,a}, active low).
module seg7_decode
    import bin2bcd_seg_seq_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [7:0] seg
);
    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (digit)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end
endmodule

// File: rtl/bin2bcd_seg_seq.sv
// Iterative double-dabble binary-to-BCD converter with registered seven-segment outputs.
// Latency: done pulses BIN_W+1 clocks after the accepted start edge; BIN_W+2 cycles per conversion.
// Backpressure: start is sampled only in IDLE; requests while busy are dropped, never queued.
// Ports: clock, reset_n (async active-low), bus (slave: start/bin_in in; busy/done/ovf/bcd_out/hex_out out).
// Build option: define BCD_BLANK_EN for leading-zero blanking of displays above digit 0.
module bin2bcd_seg_seq
    import bin2bcd_seg_seq_pkg::*;
#(
    parameter int BIN_W  = 10,
    parameter int DIGITS = 3
) (
    input  logic              clock,
    input  logic              reset_n,
    bin2bcd_seg_seq_if.slave  bus
);
    localparam int          ACC_D = acc_digits(BIN_W, DIGITS);
    localparam int          ACC_W = 4 * ACC_D;
    localparam int          OUT_W = 4 * DIGITS;
    localparam int          HEX_W = 8 * DIGITS;
    localparam int          CNT_W = $clog2(BIN_W + 1);
    localparam logic [63:0] LIMIT = pow10(DIGITS) - 64'd1;

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   sr_q;
    logic [ACC_W-1:0]   acc_q, acc_adj;
    logic [CNT_W-1:0]   cnt_q;
    logic               ovfp_q;
    logic [OUT_W-1:0]   bcd_q, bcd_ld;
    logic [HEX_W-1:0]   hex_q, hex_ld;
    logic               ovf_q, done_q;
    logic [DIGITS-1:0]  blank;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.start) state_d = ST_SHIFT;
            ST_SHIFT: if (cnt_q == CNT_W'(1)) state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Add-3 correction on every digit before it is doubled by the shift.
    always_comb begin
        acc_adj = acc_q;
        for (int d = 0; d < ACC_D; d++) begin
            if (acc_q[4*d +: 4] >= 4'd5) acc_adj[4*d +: 4] = acc_q[4*d +: 4] + 4'd3;
        end
    end

    assign bcd_ld = ovfp_q ? {DIGITS{4'h9}} : acc_q[OUT_W-1:0];

`ifdef BCD_BLANK_EN
    // Blank a display when it and every display above it hold zero; never on overflow.
    logic zero_hi;
    always_comb begin
        blank   = '0;
        zero_hi = !ovfp_q;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_hi  = zero_hi && (bcd_ld[4*i +: 4] == 4'd0);
            blank[i] = zero_hi;
        end
    end
`else
    assign blank = '0;
`endif

    for (genvar g = 0; g < DIGITS; g++) begin : g_seg
        seg7_decode u_seg (
            .digit (bcd_ld[4*g +: 4]),
            .blank (blank[g]),
            .seg   (hex_ld[8*g +: 8])
        );
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sr_q   <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            ovfp_q <= 1'b0;
            bcd_q  <= '0;
            hex_q  <= {DIGITS{SEG_0}};
            ovf_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        sr_q   <= bus.bin_in;
                        acc_q  <= '0;
                        cnt_q  <= CNT_W'(BIN_W);
                        ovfp_q <= (64'(bus.bin_in) > LIMIT);
                    end
                end
                ST_SHIFT: begin
                    // {acc,sr} shifts left as one register; the top bit of acc falls off.
                    acc_q <= (acc_adj << 1) | ACC_W'(sr_q[BIN_W-1]);
                    sr_q  <= sr_q << 1;
                    cnt_q <= cnt_q - CNT_W'(1);
                end
                ST_LOAD: begin
                    bcd_q  <= bcd_ld;
                    hex_q  <= hex_ld;
                    ovf_q  <= ovfp_q;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = (state_q != ST_IDLE);
    assign bus.done    = done_q;
    assign bus.ovf     = ovf_q;
    assign bus.bcd_out = bcd_q;
    assign bus.hex_out = hex_q;

endmodule

// File: tb/tb_bin2bcd_seg_seq.sv
// Self-checking bench for bin2bcd_seg_seq: a 3-digit and a 4-digit instance share stimulus.
// Latency: expects done 11 clocks after each accepted start (BIN_W=10).
// Backpressure: exercises start-while-busy and start-during-done.
// Build option: BCD_BLANK_EN selects the blanked display expectations.
module tb_bin2bcd_seg_seq;

    logic       clock = 1'b0;
    logic       reset_n = 1'b1;
    logic       start = 1'b0;
    logic [9:0] bin_in = '0;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clock = ~clock;

    bin2bcd_seg_seq_if #(.BIN_W(10), .DIGITS(3)) if3 ();
    bin2bcd_seg_seq_if #(.BIN_W(10), .DIGITS(4)) if4 ();

    assign if3.start  = start;
    assign if3.bin_in = bin_in;
    assign if4.start  = start;
    assign if4.bin_in = bin_in;

    bin2bcd_seg_seq #(.BIN_W(10), .DIGITS(3)) dut3 (.clock(clock), .reset_n(reset_n), .bus(if3.slave));
    bin2bcd_seg_seq #(.BIN_W(10), .DIGITS(4)) dut4 (.clock(clock), .reset_n(reset_n), .bus(if4.slave));

    // ---------------- reference model: decimal arithmetic ----------------
    function automatic longint p10(input int n);
        longint r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [63:0] m_bcd(input int v, input int d);
        logic [63:0] r = '0;
        for (int i = 0; i < d; i++) begin
            if (v >= p10(d)) r[4*i +: 4] = 4'h9;
            else             r[4*i +: 4] = 4'((v / p10(i)) % 10);
        end
        return r;
    endfunction

    function automatic logic [63:0] m_hex(input int v, input int d);
        logic [7:0]  tab [10];
        logic [63:0] r = '0;
        logic [63:0] b;
        tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
        b = m_bcd(v, d);
        for (int i = 0; i < d; i++) begin
            r[8*i +: 8] = tab[b[4*i +: 4]];
`ifdef BCD_BLANK_EN
            if (i > 0 && v < p10(d) && v < p10(i)) r[8*i +: 8] = 8'hFF;
`endif
        end
        return r;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    task automatic chk_both(input int v);
        chk("bcd3", if3.bcd_out, m_bcd(v, 3));
        chk("hex3", if3.hex_out, m_hex(v, 3));
        chk("ovf3", if3.ovf, (v >= 1000) ? 64'd1 : 64'd0);
        chk("bcd4", if4.bcd_out, m_bcd(v, 4));
        chk("hex4", if4.hex_out, m_hex(v, 4));
        chk("ovf4", if4.ovf, 64'd0);
    endtask

    // Start a conversion; lat = clocks from the accepted start edge to done (-1 on timeout).
    task automatic do_conv(input int v, output int lat);
        @(negedge clock);
        bin_in = 10'(v);
        start  = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clock);
            #1;
            if (if3.done) begin
                lat = c;
                break;
            end
        end
        if (lat < 0) begin
            n_chk++;
            $display("FAIL conv_timeout: value %0d, no done within 40 cycles", v);
        end
    endtask

    typedef struct {
        int          bin;
        logic [11:0] bcd;
        logic        ovf;
        logic [23:0] hex_plain;
        logic [23:0] hex_blank;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int lat, first, second, nd, ndone_abort;
        logic [11:0] b1, b2;

        vecs[0] = '{22,   12'h022, 1'b0, 24'hC0A4A4, 24'hFFA4A4};
        vecs[1] = '{999,  12'h999, 1'b0, 24'h909090, 24'h909090};
        vecs[2] = '{1000, 12'h999, 1'b1, 24'h909090, 24'h909090};
        vecs[3] = '{0,    12'h000, 1'b0, 24'hC0C0C0, 24'hFFFFC0};
        vecs[4] = '{5,    12'h005, 1'b0, 24'hC0C092, 24'hFFFF92};
        vecs[5] = '{1023, 12'h999, 1'b1, 24'h909090, 24'h909090};
        vecs[6] = '{100,  12'h100, 1'b0, 24'hF9C0C0, 24'hF9C0C0};

        // ---- reset state ----
        #2 reset_n = 1'b0;
        #1;
        chk("rst_busy", if3.busy, 0);
        chk("rst_done", if3.done, 0);
        chk("rst_ovf",  if3.ovf, 0);
        chk("rst_bcd",  if3.bcd_out, 0);
        chk("rst_hex3", if3.hex_out, 64'hC0C0C0);
        chk("rst_hex4", if4.hex_out, 64'hC0C0C0C0);
        repeat (2) @(posedge clock);
        @(negedge clock) reset_n = 1'b1;

        // ---- table-driven vectors ----
        for (int i = 0; i < 7; i++) begin
            do_conv(vecs[i].bin, lat);
            chk("latency", lat, 11);
            chk("busy_at_done", if3.busy, 0);
            chk("tbl_bcd", if3.bcd_out, vecs[i].bcd);
            chk("tbl_ovf", if3.ovf, vecs[i].ovf);
`ifdef BCD_BLANK_EN
            chk("tbl_hex", if3.hex_out, vecs[i].hex_blank);
`else
            chk("tbl_hex", if3.hex_out, vecs[i].hex_plain);
`endif
            @(posedge clock);
            #1 chk("done_one_cycle", if3.done, 0);
        end

        // ---- start while busy is ignored, then start during done ----
        @(negedge clock);
        bin_in = 10'd25;
        start  = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        first = -1; second = -1; nd = 0; b1 = '0; b2 = '0;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clock);
            #1;
            if (first > 0 && c == first + 1) start = 1'b0;
            if (c == 4) start = 1'b0;
            if (c == 5) chk("busy_mid", if3.busy, 1);
            if (if3.done) begin
                nd++;
                if (nd == 1) begin
                    first = c;
                    b1 = if3.bcd_out;
                    start = 1'b1;
                    bin_in = 10'd7;
                end else if (nd == 2) begin
                    second = c;
                    b2 = if3.bcd_out;
                end
            end
            if (c == 3) begin
                start = 1'b1;
                bin_in = 10'd7;
            end
        end
        chk("ign_first_lat", first, 11);
        chk("ign_bcd", b1, 12'h025);
        chk("b2b_done_count", nd, 2);
        chk("b2b_spacing", second - first, 12);
        chk("b2b_bcd", b2, 12'h007);

        // ---- reset mid-conversion ----
        do_conv(1000, lat);
        chk("pre_abort_ovf", if3.ovf, 1);
        @(negedge clock);
        bin_in = 10'd512;
        start  = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (5) @(posedge clock);
        #3 reset_n = 1'b0;
        #1;
        chk("abort_busy", if3.busy, 0);
        chk("abort_done", if3.done, 0);
        chk("abort_ovf",  if3.ovf, 0);
        chk("abort_bcd",  if3.bcd_out, 0);
        chk("abort_hex",  if3.hex_out, 64'hC0C0C0);
        chk("abort_busy4", if4.busy, 0);
        repeat (2) @(posedge clock);
        @(negedge clock) reset_n = 1'b1;
        ndone_abort = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clock);
            #1 if (if3.done || if4.done) ndone_abort++;
        end
        chk("abort_no_done", ndone_abort, 0);
        do_conv(512, lat);
        chk("after_abort_lat", lat, 11);
        chk("after_abort_bcd", if3.bcd_out, 12'h512);
        chk_both(512);

        // ---- randomized values with idle gaps against the model ----
        for (int i = 0; i < 60; i++) begin
            int v;
            repeat ($urandom_range(0, 3)) @(posedge clock);
            v = int'($urandom_range(0, 1023));
            do_conv(v, lat);
            chk("rand_lat", lat, 11);
            chk_both(v);
        end

        // ---- full sweep: 4-digit instance never overflows ----
        for (int v = 0; v < 1024; v++) begin
            do_conv(v, lat);
            chk_both(v);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
